// File: rtl/fact_accel_if.sv
// rtl/fact_accel_if.sv - register bus between the SoC data path and the factorial accelerator
interface fact_accel_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       a;
  logic             we;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;
  logic             irq;

  modport master (
    output a,
    output we,
    output wd,
    input  rd,
    input  irq
  );

  modport slave (
    input  a,
    input  we,
    input  wd,
    output rd,
    output irq
  );
endinterface

// File: rtl/fact_accel.sv
// rtl/fact_accel.sv - memory-mapped iterative factorial accelerator
module fact_accel #(
  parameter int WIDTH = 32,
  parameter int N_W   = 5,
  parameter int MAX_N = 20
) (
  input  logic         clk,
  input  logic         rst,
  fact_accel_if.slave  bus
);

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  localparam logic [2:0] ADDR_N      = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_RESULT = 3'd3;
  localparam logic [2:0] ADDR_CYCLES = 3'd4;

  state_t state, state_next;

  logic [N_W-1:0]     n_reg;
  logic               ie;
  logic               done;
  logic               err;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   cycles;
  logic [WIDTH-1:0]   acc;
  logic [N_W-1:0]     cnt;

  logic               busy;
  logic               go;
  logic               w1c;
  logic               start;
  logic               start_err;
  logic               finish;
  logic               ovf_err;
  logic               step;
  logic [2*WIDTH-1:0] prod;
  logic               ovf;
  logic               unused_wd_hi;

  assign busy = (state == CALC);
  assign go   = bus.we && (bus.a == ADDR_CTRL) && bus.wd[0];
  assign w1c  = bus.we && (bus.a == ADDR_STATUS) && bus.wd[0];

  // Full-width product so any spill into the upper half flags overflow.
  assign prod = {{WIDTH{1'b0}}, acc} * {{(2*WIDTH-N_W){1'b0}}, cnt};
  assign ovf  = |prod[2*WIDTH-1:WIDTH];

  // Data bits above the N field are never stored by any register.
  assign unused_wd_hi = ^bus.wd[WIDTH-1:N_W];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and one-cycle datapath strobes.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    start_err  = 1'b0;
    finish     = 1'b0;
    ovf_err    = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          if (32'(n_reg) > MAX_N) begin
            start_err = 1'b1;
          end else begin
            start      = 1'b1;
            state_next = CALC;
          end
        end
      end
      CALC: begin
        if (cnt <= N_W'(1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else if (ovf) begin
          ovf_err    = 1'b1;
          state_next = IDLE;
        end else begin
          step = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Register file and datapath; later assignments override earlier ones so set beats W1C.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_reg  <= '0;
      ie     <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      cycles <= '0;
      acc    <= WIDTH'(1);
      cnt    <= '0;
    end else begin
      if (bus.we && (bus.a == ADDR_N)) begin
        n_reg <= bus.wd[N_W-1:0];
      end
      if (bus.we && (bus.a == ADDR_CTRL)) begin
        ie <= bus.wd[1];
      end
      if (w1c) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (start || start_err) begin
        done   <= 1'b0;
        err    <= 1'b0;
        cycles <= '0;
      end
      if (start_err) begin
        err    <= 1'b1;
        done   <= 1'b1;
        result <= '0;
      end
      if (start) begin
        cnt <= n_reg;
        acc <= WIDTH'(1);
      end
      if (finish) begin
        result <= acc;
        done   <= 1'b1;
      end
      if (ovf_err) begin
        err    <= 1'b1;
        done   <= 1'b1;
        result <= '0;
      end
      if (step) begin
        acc    <= prod[WIDTH-1:0];
        cnt    <= cnt - N_W'(1);
        cycles <= cycles + WIDTH'(1);
      end
    end
  end

  // Read mux; unmapped addresses and unused bits read as zero.
  always_comb begin
    bus.rd = '0;
    case (bus.a)
      ADDR_N:      bus.rd = {{(WIDTH-N_W){1'b0}}, n_reg};
      ADDR_CTRL:   bus.rd = {{(WIDTH-2){1'b0}}, ie, 1'b0};
      ADDR_STATUS: bus.rd = {{(WIDTH-3){1'b0}}, busy, err, done};
      ADDR_RESULT: bus.rd = result;
      ADDR_CYCLES: bus.rd = cycles;
      default:     bus.rd = '0;
    endcase
  end

  assign bus.irq = done & ie;

endmodule
